// File: rtl/stepper_step_scheduler.sv
// Single-axis stepper move sequencer: paces steps through an external delay
// counter and drives coil phases. Define HALF_STEP_EN for the 8-entry half-step table.
module stepper_step_scheduler #(
  parameter int STEP_W  = 16,
  parameter int DELAY_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEP_W-1:0]  cmd_steps,
  input  logic [DELAY_W-1:0] cmd_delay,
  input  logic               abort,
  output logic               dc_start,
  output logic               dc_enable,
  output logic [DELAY_W-1:0] dc_delay,
  input  logic               dc_done,
  output logic [3:0]         coils,
  output logic               step_pulse,
  output logic               busy,
  output logic [STEP_W-1:0]  steps_left,
  output logic               move_done,
  output logic               move_aborted
);

`ifdef HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_STEP,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [STEP_W-1:0]  steps_left_q, steps_left_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               energized_q, energized_d;
  logic               aborted_q, aborted_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dir_q        <= 1'b0;
      steps_left_q <= '0;
      delay_q      <= '0;
      phase_q      <= '0;
      energized_q  <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      steps_left_q <= steps_left_d;
      delay_q      <= delay_d;
      phase_q      <= phase_d;
      energized_q  <= energized_d;
      aborted_q    <= aborted_d;
    end
  end

  // abort takes priority over dc_done and over the step in STEP: nothing moves that cycle
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    steps_left_d = steps_left_q;
    delay_d      = delay_q;
    phase_d      = phase_q;
    energized_d  = energized_q;
    aborted_d    = aborted_q;
    cmd_ready    = 1'b0;
    dc_start     = 1'b0;
    dc_enable    = 1'b0;
    step_pulse   = 1'b0;
    move_done    = 1'b0;
    move_aborted = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          dir_d        = cmd_dir;
          steps_left_d = cmd_steps;
          delay_d      = cmd_delay;
          energized_d  = 1'b1;
          aborted_d    = 1'b0;
          state_d      = (cmd_steps == '0) ? S_FINISH : S_ARM;
        end
      end
      S_ARM: begin
        dc_start = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          dc_enable = 1'b1;
          if (dc_done) state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          step_pulse   = 1'b1;
          phase_d      = dir_q ? phase_q + PH_W'(1) : phase_q - PH_W'(1);
          steps_left_d = steps_left_q - STEP_W'(1);
          state_d      = (steps_left_q == STEP_W'(1)) ? S_FINISH : S_WAIT;
        end
      end
      S_FINISH: begin
        move_done    = 1'b1;
        move_aborted = aborted_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    coils = '0;
    if (energized_q) begin
`ifdef HALF_STEP_EN
      case (phase_q)
        3'd0:    coils = 4'b1000;
        3'd1:    coils = 4'b1100;
        3'd2:    coils = 4'b0100;
        3'd3:    coils = 4'b0110;
        3'd4:    coils = 4'b0010;
        3'd5:    coils = 4'b0011;
        3'd6:    coils = 4'b0001;
        default: coils = 4'b1001;
      endcase
`else
      case (phase_q)
        2'd0:    coils = 4'b1100;
        2'd1:    coils = 4'b0110;
        2'd2:    coils = 4'b0011;
        default: coils = 4'b1001;
      endcase
`endif
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign dc_delay   = delay_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_stepper_step_scheduler.sv
// Scoreboard bench for stepper_step_scheduler: behavioural phase/step model,
// delay-counter model, and a negedge monitor. Honours HALF_STEP_EN like the DUT.
module tb_stepper_step_scheduler;
  localparam int STEP_W  = 16;
  localparam int DELAY_W = 8;

`ifdef HALF_STEP_EN
  localparam int NPH = 8;
`else
  localparam int NPH = 4;
`endif

  logic               clk, reset;
  logic               cmd_valid, cmd_ready, cmd_dir, abort;
  logic [STEP_W-1:0]  cmd_steps, steps_left;
  logic [DELAY_W-1:0] cmd_delay, dc_delay;
  logic               dc_start, dc_enable, dc_done;
  logic [3:0]         coils;
  logic               step_pulse, busy, move_done, move_aborted;

  stepper_step_scheduler #(.STEP_W(STEP_W), .DELAY_W(DELAY_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_delay(cmd_delay), .abort(abort),
    .dc_start(dc_start), .dc_enable(dc_enable), .dc_delay(dc_delay),
    .dc_done(dc_done), .coils(coils), .step_pulse(step_pulse), .busy(busy),
    .steps_left(steps_left), .move_done(move_done), .move_aborted(move_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Delay counter: loads on dc_start, counts while enabled, done once count exceeds delay.
  int cnt, ldv;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 0; ldv <= 0; dc_done <= 1'b0;
    end else begin
      if (dc_start) ldv <= int'(dc_delay);
      if (!dc_enable) begin
        cnt <= 0; dc_done <= 1'b0;
      end else begin
        cnt <= cnt + 1;
        if (cnt + 1 >= ldv + 1) dc_done <= 1'b1;
      end
    end
  end

  function automatic logic [3:0] ptab(input int i);
`ifdef HALF_STEP_EN
    case (i)
      0: return 4'b1000; 1: return 4'b1100; 2: return 4'b0100; 3: return 4'b0110;
      4: return 4'b0010; 5: return 4'b0011; 6: return 4'b0001; default: return 4'b1001;
    endcase
`else
    case (i)
      0: return 4'b1100; 1: return 4'b0110; 2: return 4'b0011; default: return 4'b1001;
    endcase
`endif
  endfunction

  typedef struct { logic [3:0] coils; int left; int gap; } step_exp_t;
  typedef struct { logic ab; int left; logic [3:0] coils; int cyc; } done_exp_t;

  step_exp_t step_q[$];
  done_exp_t done_q[$];
  int        start_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int  idx = 0;
  bit  ener = 0;

  // Monitor: pops expectations whenever the DUT strobes an event.
  bit        pend = 0;
  step_exp_t pe;
  int        last_step = 0;
  always @(negedge clk) begin
    if (reset) begin
      pend = 0;
    end else begin
      if (pend) begin
        chk("step_coils", 32'(coils), 32'(pe.coils));
        chk("step_left", 32'(steps_left), 32'(pe.left));
        pend = 0;
      end
      if (step_pulse) begin
        if (step_q.size() == 0) chk("unexpected_step", 1, 0);
        else begin
          pe = step_q.pop_front();
          if (pe.gap > 0) chk("step_gap", 32'(cyc - last_step), 32'(pe.gap));
          last_step = cyc;
          pend = 1;
        end
      end
      if (dc_start) begin
        if (start_q.size() == 0) chk("unexpected_start", 1, 0);
        else chk("dc_delay", 32'(dc_delay), 32'(start_q.pop_front()));
      end
      if (move_done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          done_exp_t d;
          d = done_q.pop_front();
          chk("done_aborted", 32'(move_aborted), 32'(d.ab));
          chk("done_left", 32'(steps_left), 32'(d.left));
          chk("done_coils", 32'(coils), 32'(d.coils));
          chk("done_dc_enable", 32'(dc_enable), 0);
          if (d.cyc >= 0) chk("done_latency", 32'(cyc), 32'(d.cyc));
        end
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_coils", 32'(coils), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dc_enable", 32'(dc_enable), 0);
    chk("rst_dc_start", 32'(dc_start), 0);
    chk("rst_dc_delay", 32'(dc_delay), 0);
    chk("rst_step", 32'(step_pulse), 0);
    chk("rst_left", 32'(steps_left), 0);
    chk("rst_done", 32'(move_done), 0);
    chk("rst_aborted", 32'(move_aborted), 0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    step_q.delete(); done_q.delete(); start_q.delete();
    idx = 0; ener = 0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // k>0: abort in the cycle of the k-th dc_done. rc>0: leave after rc cycles (caller resets).
  task automatic do_move(input bit dir, input int steps, input int delay, input int k, input int rc);
    int  n, nd;
    bit  ok, b, d;
    done_exp_t de;
    ener = 1;
    if (steps > 0) start_q.push_back(delay);
    n = (k > 0) ? k - 1 : steps;
    for (int i = 1; i <= n; i++) begin
      idx = dir ? (idx + 1) % NPH : (idx + NPH - 1) % NPH;
      step_q.push_back('{coils: ptab(idx), left: steps - i, gap: (i == 1) ? 0 : delay + 3});
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = dir;
    cmd_steps = STEP_W'(steps); cmd_delay = DELAY_W'(delay);
    @(posedge clk);
    #1;
    de = '{ab: (k > 0), left: steps - n, coils: ptab(idx), cyc: (steps == 0) ? cyc : -1};
    done_q.push_back(de);
    cmd_valid = 1'b0;
    ok = 0; nd = 0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      b = busy;
      d = dc_done && dc_enable;
      abort = 1'b0;
      if (!b || (rc > 0 && t == rc)) begin
        cmd_valid = 1'b0;
        ok = 1;
        break;
      end
      if (d) begin
        nd++;
        if (nd == k) abort = 1'b1;
      end
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_dir   = 1'($urandom);
      cmd_steps = STEP_W'($urandom_range(0, 3));
      cmd_delay = DELAY_W'($urandom_range(0, 3));
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    if (!ok) chk("move_timeout", 0, 1);
  endtask

  task automatic idle_abort_noise();
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; cmd_delay = '0; abort = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk); #2 reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_coils", 32'(coils), 0);
      chk("idle_ready", 32'(cmd_ready), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_dc_enable", 32'(dc_enable), 0);
    end

    do_move(1'b1, 5, 3, 0, 0);
    do_move(1'b0, 0, 2, 0, 0);
    idle_abort_noise();
    reset_dut();
    do_move(1'b0, 2, 1, 0, 0);
    do_move(1'b1, 10, 2, 3, 0);
    reset_dut();
    do_move(1'b1, 9, 1, 0, 0);
    do_move(1'b1, 6, 2, 0, 12);
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_coils", 32'(coils), 0);
    end

    for (int m = 0; m < 25; m++) begin
      int st, dl, k;
      st = $urandom_range(0, 7);
      dl = $urandom_range(0, 4);
      k  = 0;
      if (st > 0 && $urandom_range(0, 9) < 3) k = $urandom_range(1, st);
      do_move(1'($urandom), st, dl, k, 0);
      if ($urandom_range(0, 3) == 0) idle_abort_noise();
    end

    repeat (3) @(negedge clk);
    chk("step_q_drained", 32'(step_q.size()), 0);
    chk("done_q_drained", 32'(done_q.size()), 0);
    chk("start_q_drained", 32'(start_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stepper_step_scheduler.md
Name: stepper_step_scheduler

Overview:
- Move sequencer for one stepper axis: accepts a move command (direction, step count, per-step delay), paces steps by driving an external delay counter (start/enable/delay in, done out), and drives 4 coil phase outputs.
- Sits between the ASIP command/register logic and the delay counter plus coil driver pins. One scheduler per delay counter instance.

Parameters:
- STEP_W, 16, width of step count and remaining-step counter
- DELAY_W, 8, width of per-step delay value; matches delay counter delay input

Ports:
- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  move command present
- cmd_ready  out  1  scheduler can accept command (IDLE only)
- cmd_dir  in  1  1 = forward (phase index +1), 0 = reverse (-1)
- cmd_steps  in  STEP_W  number of steps to issue
- cmd_delay  in  DELAY_W  delay value handed to counter per step
- abort  in  1  terminate current move
- dc_start  out  1  one-cycle load strobe to delay counter
- dc_enable  out  1  delay counter enable; low clears counter done/count
- dc_delay  out  DELAY_W  delay value to counter (latched cmd_delay)
- dc_done  in  1  delay counter expiry (level, held until enable low)
- coils  out  4  coil drive pattern {A,B,C,D}
- step_pulse  out  1  one-cycle strobe per issued step
- busy  out  1  high in any state except IDLE
- steps_left  out  STEP_W  remaining steps
- move_done  out  1  one-cycle strobe at end of move
- move_aborted  out  1  valid with move_done; 1 = ended by abort

Behaviour:
- Reset (async): state IDLE, cmd_ready=1, dc_start=0, dc_enable=0, dc_delay=0, coils=4'b0000, step_pulse=0, busy=0, steps_left=0, move_done=0, move_aborted=0, phase index=0, energized=0.
- coils = 0 while energized=0; else table[phase index]. energized set on first accepted command, cleared only by reset (holding torque between moves).
- Full-step table (index 0..3): 1100, 0110, 0011, 1001. Index wraps mod 4 both directions (3+1->0, 0-1->3).
- States: IDLE, ARM, WAIT, STEP, FINISH.
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready: latch dir, steps into steps_left, delay into dc_delay. cmd_steps==0 -> FINISH (no dc activity, no step). Else -> ARM.
- ARM (1 cycle): dc_start=1, dc_enable=0 -> WAIT.
- WAIT: dc_enable=1; stay until dc_done=1 -> STEP.
- STEP (1 cycle): dc_enable=0 (clears counter), step_pulse=1, phase index +/-1, steps_left-1. New steps_left==0 -> FINISH, else -> WAIT. Coils update on STEP exit edge.
- FINISH (1 cycle): move_done=1, dc_enable=0 -> IDLE. move_aborted=1 only if entered by abort.
- abort (ARM/WAIT/STEP): next state FINISH, dc_enable=0, no step issued that cycle even if dc_done=1 (abort wins); steps_left frozen. abort in IDLE/FINISH ignored.
- cmd_valid outside IDLE ignored (not queued).
- Step period = counter expiry time + 2 clk (STEP + re-enable).
- Reset mid-move: all outputs to reset values immediately, coils de-energized.

Optional Feature:
- HALF_STEP_EN: defined -> 3-bit phase index, 8-entry table 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001, wrap mod 8; reset index 0. Undefined -> 2-bit full-step table above. Handshake and timing identical.

Test Plan:
- Reset then idle: coils=0000, cmd_ready=1, busy=0, dc_enable=0 -> all hold over 20 clk.
- Forward move: dir=1, steps=5, delay=3, bench counter model asserting dc_done 4 clk after enable rises -> dc_start one pulse, dc_delay=3, 5 step_pulses spaced 6 clk, coils 0110,0011,1001,1100,0110, single move_done with move_aborted=0, steps_left=0.
- Reverse wrap: from index 0, dir=0, steps=2 -> coils 1001 then 0011; index 3 then 2.
- Zero steps: steps=0 -> move_done 1 clk after accept, no dc_start, no step_pulse, coils unchanged.
- Abort race: steps=10, assert abort in same cycle as 3rd dc_done -> exactly 2 step_pulses, steps_left=8, move_done with move_aborted=1, dc_enable low next cycle.
- HALF_STEP_EN build: dir=1, steps=9 from reset -> coils 1100,0100,0110,0010,0011,0001,1001,1000,1100 (index wraps 7->0).
